// File: rtl/encoder_4to2_rr.sv
// rtl/encoder_4to2_rr.sv - sequential 4-to-2 encoder with sticky pending requests and arbitration
//
// Collects request lines R0..R3 into a sticky pending register. It picks one
// pending line per cycle, either round-robin or by fixed priority, and
// presents its index on S1:S0 with a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   R0..R3     request lines
//   S0, S1     granted index code (S1 is the MSB)
//   out_valid  code on S1:S0 is valid
//   out_ready  consumer accepts the code this cycle
//   multi      another request besides the presented one is pending
//   drop_cnt   saturating count of edges where a request hit an already-pending line
module encoder_4to2_rr #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             R0,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3,
  output logic             S0,
  output logic             S1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             multi,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  logic [3:0]       pending;
  logic [1:0]       ptr;
  logic [1:0]       code;

  logic [3:0]       req;
  logic [1:0]       search_base;
  logic [1:0]       win;
  logic             any_pending;
  logic             grant;
  logic [3:0]       clr;
  logic [3:0]       pending_next;
  logic             collide;
  logic             valid_next;
  logic [CNT_W-1:0] cnt_max;

  assign req         = {R3, R2, R1, R0};
  assign any_pending = |pending;
  assign cnt_max     = '1;

  // With fixed priority the search always starts at index 0.
  assign search_base = (RR_EN != 0) ? ptr : 2'd0;

  // Walk the offsets from farthest to nearest. The nearest set bit is
  // assigned last, so it wins. The 2-bit sum wraps modulo 4.
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[search_base + 2'(i)]) begin
        win = search_base + 2'(i);
      end
    end
  end

  // A grant happens in IDLE, or in HOLD once the current code is taken.
  always_comb begin
    grant = 1'b0;
    case (state)
      IDLE:    grant = any_pending;
      HOLD:    grant = any_pending && out_ready;
      default: grant = 1'b0;
    endcase
  end

  assign clr          = grant ? (4'b0001 << win) : 4'b0000;
  // OR-ing req in last lets a same-edge request beat the grant clear.
  assign pending_next = (pending & ~clr) | req;
  assign collide      = |(req & pending & ~clr);
  assign valid_next   = grant || ((state == HOLD) && !out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= 4'b0000;
      ptr       <= 2'd0;
      code      <= 2'd0;
      out_valid <= 1'b0;
      multi     <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      pending <= pending_next;
      multi   <= valid_next && (|pending_next);

      if (collide && (drop_cnt != cnt_max)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

      if (grant) begin
        code <= win;
        if (RR_EN != 0) begin
          ptr <= win + 2'd1;
        end
      end

      case (state)
        IDLE: begin
          out_valid <= grant;
          state     <= grant ? HOLD : IDLE;
        end
        HOLD: begin
          // Stalled, or re-granted back-to-back: both keep valid high.
          // The code is held when dropping back to IDLE.
          out_valid <= valid_next;
          state     <= valid_next ? HOLD : IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign S0 = code[0];
  assign S1 = code[1];

endmodule

// File: doc/encoder_4to2_rr.md
Name: encoder_4to2_rr

Overview:
- Sequential 4-to-2 encoder; performs the inverse function of the 2-to-4 decoder in the 4-bit ALU datapath.
- Collects request lines R0..R3, for example unit-done or operation-request strobes, into a sticky pending register.
- Arbitrates among pending requests round-robin or by fixed priority.
- Presents the winning index as a 2-bit code S1:S0 with a valid/ready handshake, so the code can drive the ALU select decoder.
- Also reports pending-collision statistics.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with R0 highest and R3 lowest.
- CNT_W, 4, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- R0  input  1  request line 0.
- R1  input  1  request line 1.
- R2  input  1  request line 2.
- R3  input  1  request line 3.
- S0  output  1  code bit 0 of the granted index.
- S1  output  1  code bit 1 of the granted index.
- out_valid  output  1  code on S1:S0 is valid.
- out_ready  input  1  consumer accepts the code this cycle.
- multi  output  1  at least one request other than the presented one is pending.
- drop_cnt  output  CNT_W  saturating count of requests that arrived while their line was already pending.

Behaviour:
- Reset (rst_n low at a clock edge):
  - pending = 4'b0000, ptr = 0, state = IDLE.
  - S1:S0 = 2'b00, out_valid = 0, multi = 0, drop_cnt = 0.
  - Reset is synchronous, so no effect occurs between edges.
  - Reset mid-handshake discards the presented code and all pending requests.
- Pending register:
  - Each edge: pending_next = (pending & ~clr) | {R3,R2,R1,R0}.
  - clr is the one-hot mask of the index granted this edge.
  - If a request arrives on the bit being cleared in the same edge, set wins and the request stays pending.
  - A line held high re-arms every cycle, so it is granted repeatedly.
- Drop counter:
  - Increments by 1 on each edge where any line Rk = 1 while pending[k] = 1 and that bit is not being cleared this edge.
  - At most +1 per edge, even if multiple lines collide.
  - Saturates at 2^CNT_W-1.
- Arbitration, RR_EN = 1:
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set pending bit wins.
  - After a grant to index k, ptr = (k+1) mod 4.
  - ptr is unchanged when no grant occurs.
- Arbitration, RR_EN = 0:
  - Lowest set index wins; ptr is unused and held at 0.
- Arbitration input is the registered pending only. The same-edge R inputs are not considered, so latency from an R pulse to out_valid is 2 edges.
- FSM:
  - IDLE: out_valid = 0. If pending != 0, then winner k is selected, {S1,S0} is loaded with k, out_valid is set to 1, pending[k] is cleared, and state goes to HOLD. Otherwise the FSM stays in IDLE.
  - HOLD: out_valid = 1. S1:S0 stays stable until accepted.
    - out_ready = 0: stay in HOLD with nothing changed.
    - out_ready = 1 and pending != 0: grant the next winner back-to-back in the same edge, load the new code, stay in HOLD. One grant per cycle is sustained.
    - out_ready = 1 and pending == 0: out_valid goes to 0, S1:S0 holds its last value, state goes to IDLE.
  - out_ready is ignored in IDLE.
- multi: registered; equals 1 when out_valid_next = 1 and pending_next != 0.
- All outputs are registered; there is no combinational path from R* or out_ready to the outputs.

Test Plan:
1. Reset and single request:
   - Stimulus: hold rst_n = 0 for 2 edges; release; pulse R2 for 1 cycle; out_ready = 1.
   - Required: outputs all 0 during reset; out_valid rises 2 edges after the R2 edge with S1:S0 = 10 and multi = 0; out_valid drops on the next edge.
2. Round-robin fairness:
   - Stimulus: RR_EN = 1; hold R0..R3 all high for 8 cycles; out_ready = 1.
   - Required: grant sequence 00, 01, 10, 11, 00, 01, ... with one grant per cycle; multi = 1 throughout; drop_cnt increments on each edge where a held line is already pending and not being cleared.
3. Fixed priority:
   - Stimulus: RR_EN = 0; pulse R1 and R3 together for one cycle; out_ready = 1.
   - Required: S1:S0 = 01 with multi = 1, then 11 with multi = 0, then out_valid = 0.
4. Backpressure:
   - Stimulus: pulse R3; hold out_ready = 0 for 5 cycles; pulse R0 during the stall; then out_ready = 1.
   - Required: S1:S0 = 11 stays stable with out_valid = 1 for all stalled cycles; multi = 1 after R0 is pending; after acceptance, next code = 00.
5. Set-wins and drop saturation:
   - Stimulus: pulse R1 on the same edge its grant clears pending[1]. Then, with CNT_W = 2 and out_ready = 0, hold R0 high for 6 cycles while pending[0] is set.
   - Required: R1 is granted again on the next cycle. drop_cnt saturates at 3.
6. Reset mid-operation:
   - Stimulus: out_valid = 1 with 3 requests pending; assert rst_n = 0 for 1 edge.
   - Required: out_valid = 0, pending cleared, drop_cnt = 0, ptr = 0; the next R2 + R0 pulse grants 00 first when RR_EN = 1.
